// File: rtl/fifo_write_arbiter.sv
// Four-requester round-robin packet arbiter feeding an async FIFO write port.
// A granted requester owns the FIFO until its last beat or until MAX_BEATS beats have been written.
module fifo_write_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BEATS  = 16
) (
   input  logic                    write_clk,
   input  logic                    write_rst_n,
   input  logic [3:0]              i_req_valid,
   input  logic [4*DATA_WIDTH-1:0] i_req_data,
   input  logic [3:0]              i_req_last,
   output logic [3:0]              o_req_ready,
   input  logic                    i_fifo_full,
   output logic                    o_fifo_write_ena,
   output logic [DATA_WIDTH+1:0]   o_fifo_write_data,
   output logic [1:0]              o_grant_id,
   output logic                    o_busy,
   output logic                    o_err_overlen
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                r_state, w_next_state;
   logic [1:0]            r_grant_id, r_last_grant;
   logic [7:0]            r_beat_cnt;
   logic                  r_err_overlen;
   logic                  w_found;
   logic [1:0]            w_winner;
   logic                  w_accept, w_cnt_max, w_end;
   logic [DATA_WIDTH-1:0] w_sel_data;

   // First valid requester after the previous winner, wrapping mod 4.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_last_grant;
      for (int k = 1; k <= 4; k++) begin
         if (!w_found && i_req_valid[2'(r_last_grant + 2'(k))]) begin
            w_found  = 1'b1;
            w_winner = 2'(r_last_grant + 2'(k));
         end
      end
   end

   assign w_sel_data = i_req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
   assign w_accept   = (r_state == GRANT) && i_req_valid[r_grant_id] && !i_fifo_full;
   assign w_cnt_max  = (r_beat_cnt == 8'(MAX_BEATS - 1));
   assign w_end      = w_accept && (i_req_last[r_grant_id] || w_cnt_max);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_found) w_next_state = GRANT;
         GRANT:   if (w_end)   w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge write_clk or negedge write_rst_n) begin
      if (!write_rst_n) begin
         r_state       <= IDLE;
         r_grant_id    <= 2'd0;
         r_last_grant  <= 2'd3;
         r_beat_cnt    <= 8'd0;
         r_err_overlen <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == IDLE && w_found) begin
            r_grant_id <= w_winner;
            r_beat_cnt <= 8'd0;
         end
         if (w_accept) r_beat_cnt <= r_beat_cnt + 8'd1;
         if (w_end) r_last_grant <= r_grant_id;
         // Forced release without a last marker is a protocol error that stays flagged.
         if (w_accept && w_cnt_max && !i_req_last[r_grant_id]) r_err_overlen <= 1'b1;
      end
   end

   always_comb begin
      o_req_ready = 4'b0000;
      if (r_state == GRANT) o_req_ready[r_grant_id] = !i_fifo_full;
   end

   assign o_fifo_write_ena  = w_accept;
   assign o_fifo_write_data = {r_grant_id, w_sel_data};
   assign o_grant_id        = r_grant_id;
   assign o_busy            = (r_state == GRANT);
   assign o_err_overlen     = r_err_overlen;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table for arbitration/stall/drop-valid,
// hand sequences for forced release and mid-packet reset.
module tb_fifo_write_arbiter;
   localparam int DW = 8;
   localparam int MB = 4;

   logic          write_clk = 1'b0;
   logic          write_rst_n;
   logic [3:0]    req_valid, req_last, req_ready;
   logic [4*DW-1:0] req_data;
   logic          fifo_full, fifo_write_ena, busy, err_overlen;
   logic [DW+1:0] fifo_write_data;
   logic [1:0]    grant_id;

   int total = 0;
   int bad   = 0;

   fifo_write_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
      .write_clk(write_clk), .write_rst_n(write_rst_n),
      .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
      .o_req_ready(req_ready), .i_fifo_full(fifo_full),
      .o_fifo_write_ena(fifo_write_ena), .o_fifo_write_data(fifo_write_data),
      .o_grant_id(grant_id), .o_busy(busy), .o_err_overlen(err_overlen)
   );

   always #5 write_clk = ~write_clk;

   typedef struct {
      logic [3:0] v, l;
      logic       f;
      logic [3:0] rdy;
      logic       we;
      logic [9:0] wd;
      logic [1:0] g;
      logic       b;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [3:0] v, l, input logic f, input logic [3:0] rdy,
                      input logic we, input logic [9:0] wd, input logic [1:0] g, input logic b);
      vec_t t;
      t.v = v; t.l = l; t.f = f; t.rdy = rdy; t.we = we; t.wd = wd; t.g = g; t.b = b;
      tbl.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, l, input logic f);
      req_valid = v; req_last = l; fifo_full = f;
   endtask

   int wcyc[$];
   int k;

   initial begin
      write_rst_n = 1'b0;
      req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      drive(4'b1111, 4'b1111, 1'b0);

      // 4 valid single-beat packets: 0,1,2,3,0 with idle bubbles
      add(4'b1111, 4'b1111, 0, 4'b0000, 0, 10'h000, 0, 0);
      add(4'b1111, 4'b1111, 0, 4'b0001, 1, 10'h0A0, 0, 1);
      add(4'b1111, 4'b1111, 0, 4'b0000, 0, 10'h000, 0, 0);
      add(4'b1111, 4'b1111, 0, 4'b0010, 1, 10'h1B1, 1, 1);
      add(4'b1111, 4'b1111, 0, 4'b0000, 0, 10'h000, 1, 0);
      add(4'b1111, 4'b1111, 0, 4'b0100, 1, 10'h2C2, 2, 1);
      add(4'b1111, 4'b1111, 0, 4'b0000, 0, 10'h000, 2, 0);
      add(4'b1111, 4'b1111, 0, 4'b1000, 1, 10'h3D3, 3, 1);
      add(4'b1111, 4'b1111, 0, 4'b0000, 0, 10'h000, 3, 0);
      add(4'b1111, 4'b1111, 0, 4'b0001, 1, 10'h0A0, 0, 1);
      // requester 2 three-beat packet while requester 0 waits
      add(4'b0101, 4'b0000, 0, 4'b0000, 0, 10'h000, 0, 0);
      add(4'b0101, 4'b0000, 0, 4'b0100, 1, 10'h2C2, 2, 1);
      add(4'b0101, 4'b0000, 0, 4'b0100, 1, 10'h2C2, 2, 1);
      add(4'b0101, 4'b0100, 0, 4'b0100, 1, 10'h2C2, 2, 1);
      add(4'b0001, 4'b0001, 0, 4'b0000, 0, 10'h000, 2, 0);
      add(4'b0001, 4'b0001, 0, 4'b0001, 1, 10'h0A0, 0, 1);
      add(4'b0000, 4'b0000, 0, 4'b0000, 0, 10'h000, 0, 0);
      add(4'b0000, 4'b0000, 0, 4'b0000, 0, 10'h000, 0, 0);
      // fifo_full for 5 cycles mid-packet
      add(4'b0010, 4'b0000, 0, 4'b0000, 0, 10'h000, 0, 0);
      add(4'b0010, 4'b0000, 0, 4'b0010, 1, 10'h1B1, 1, 1);
      for (int i = 0; i < 5; i++) add(4'b0010, 4'b0000, 1, 4'b0000, 0, 10'h000, 1, 1);
      add(4'b0010, 4'b0010, 0, 4'b0010, 1, 10'h1B1, 1, 1);
      // granted requester 0 drops valid while others request
      add(4'b0001, 4'b0000, 0, 4'b0000, 0, 10'h000, 1, 0);
      add(4'b0001, 4'b0000, 0, 4'b0001, 1, 10'h0A0, 0, 1);
      for (int i = 0; i < 3; i++) add(4'b1110, 4'b0000, 0, 4'b0001, 0, 10'h000, 0, 1);
      add(4'b1111, 4'b0001, 0, 4'b0001, 1, 10'h0A0, 0, 1);
      add(4'b0000, 4'b0000, 0, 4'b0000, 0, 10'h000, 0, 0);

      // reset state with requests present
      @(negedge write_clk); #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_we", 32'(fifo_write_ena), 0);
      chk("rst_err", 32'(err_overlen), 0);
      chk("rst_grant", 32'(grant_id), 0);
      @(negedge write_clk);
      write_rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].l, tbl[i].f);
         #1;
         chk($sformatf("row%0d_rdy", i), 32'(req_ready), 32'(tbl[i].rdy));
         chk($sformatf("row%0d_we", i), 32'(fifo_write_ena), 32'(tbl[i].we));
         if (tbl[i].we) chk($sformatf("row%0d_wd", i), 32'(fifo_write_data), 32'(tbl[i].wd));
         chk($sformatf("row%0d_gnt", i), 32'(grant_id), 32'(tbl[i].g));
         chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].b));
         chk($sformatf("row%0d_err", i), 32'(err_overlen), 0);
         @(negedge write_clk);
      end

      // requester 1 streams 6 beats with last=0, MAX_BEATS=4
      k = 0;
      for (int c = 0; c < 10; c++) begin
         req_data[15:8] = 8'h10 + 8'(k);
         drive((k < 6) ? 4'b0010 : 4'b0000, 4'b0000, 1'b0);
         #1;
         if (fifo_write_ena) begin
            chk($sformatf("ovl_wd%0d", k), 32'(fifo_write_data), 32'({2'd1, 8'h10 + 8'(k)}));
            wcyc.push_back(c);
            k++;
         end
         @(negedge write_clk);
      end
      chk("ovl_nwrites", 32'(wcyc.size()), 6);
      if (wcyc.size() == 6) begin
         chk("ovl_c0", 32'(wcyc[0]), 1);
         chk("ovl_c3", 32'(wcyc[3]), 4);
         chk("ovl_c4", 32'(wcyc[4]), 6);
         chk("ovl_c5", 32'(wcyc[5]), 7);
      end
      chk("ovl_err", 32'(err_overlen), 1);
      chk("ovl_busy", 32'(busy), 1);
      chk("ovl_gnt", 32'(grant_id), 1);

      // finish req1, run a req0 packet, then reset during beat 2 of the next req0 packet
      req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      drive(4'b0010, 4'b0010, 1'b0); #1;
      chk("fin1_we", 32'(fifo_write_ena), 1);
      @(negedge write_clk); drive(4'b0001, 4'b0001, 1'b0); #1;
      chk("fin1_idle", 32'(busy), 0);
      @(negedge write_clk); drive(4'b0001, 4'b0001, 1'b0); #1;
      chk("p0_wd", 32'(fifo_write_data), 32'h0A0);
      chk("p0_we", 32'(fifo_write_ena), 1);
      @(negedge write_clk); drive(4'b0001, 4'b0000, 1'b0);
      @(negedge write_clk); drive(4'b0001, 4'b0000, 1'b0); #1;
      chk("b1_we", 32'(fifo_write_ena), 1);
      @(negedge write_clk); drive(4'b0011, 4'b0000, 1'b0); #1;
      chk("b2_we", 32'(fifo_write_ena), 1);
      write_rst_n = 1'b0; #1;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_ready", 32'(req_ready), 0);
      chk("mrst_we", 32'(fifo_write_ena), 0);
      chk("mrst_err", 32'(err_overlen), 0);
      @(negedge write_clk); write_rst_n = 1'b1; #1;
      chk("post_idle", 32'(busy), 0);
      @(negedge write_clk); #1;
      chk("post_gnt", 32'(grant_id), 0);
      chk("post_busy", 32'(busy), 1);
      chk("post_ready", 32'(req_ready), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
